// File: rtl/pll_mode_pkg.sv
// Shared types, divider table and encoders for the rPLL mode sequencer.
package pll_mode_pkg;

  // One rPLL divider set; divider fields hold the *_SEL attribute values,
  // pclk_tag is the nominal pixel clock in units of 100 kHz.
  typedef struct packed {
    logic [5:0]  idiv;
    logic [5:0]  fbdiv;
    logic [7:0]  odiv;
    logic [15:0] pclk_tag;
  } mode_t;

  localparam int MAX_MODES = 8;

  // Entries 4..7 repeat the 480p fallback so any NUM_MODES up to 8 indexes
  // a sane divider set.
  localparam mode_t MODE_TABLE [MAX_MODES] = '{
    '{idiv: 6'd2, fbdiv: 6'd13, odiv: 8'd4, pclk_tag: 16'd252},  // 480p
    '{idiv: 6'd3, fbdiv: 6'd54, odiv: 8'd2, pclk_tag: 16'd742},  // 720p
    '{idiv: 6'd4, fbdiv: 6'd60, odiv: 8'd2, pclk_tag: 16'd659},  // 1080p30 RB2
    '{idiv: 6'd4, fbdiv: 6'd56, odiv: 8'd2, pclk_tag: 16'd616},  // 1120x832
    '{idiv: 6'd2, fbdiv: 6'd13, odiv: 8'd4, pclk_tag: 16'd252},
    '{idiv: 6'd2, fbdiv: 6'd13, odiv: 8'd4, pclk_tag: 16'd252},
    '{idiv: 6'd2, fbdiv: 6'd13, odiv: 8'd4, pclk_tag: 16'd252},
    '{idiv: 6'd2, fbdiv: 6'd13, odiv: 8'd4, pclk_tag: 16'd252}
  };

  typedef enum logic [1:0] {PRST, WLOCK, STAB, RUN} state_t;

  // rPLL ODSEL code for a given output divider.
  function automatic logic [5:0] odsel_enc(input logic [7:0] odiv);
    case (odiv)
      8'd2:    return 6'b111111;
      8'd4:    return 6'b111110;
      8'd8:    return 6'b111100;
      8'd16:   return 6'b111000;
      8'd32:   return 6'b110000;
      8'd48:   return 6'b101000;
      8'd64:   return 6'b100000;
      8'd80:   return 6'b011000;
      8'd96:   return 6'b010000;
      8'd112:  return 6'b001000;
      8'd128:  return 6'b000000;
      default: return 6'b111111;
    endcase
  endfunction

  // {idsel, fbdsel, odsel} as driven onto the rPLL dynamic ports.
  function automatic logic [17:0] mode_sels(input logic [2:0] idx);
    return {~MODE_TABLE[idx].idiv, ~MODE_TABLE[idx].fbdiv,
            odsel_enc(MODE_TABLE[idx].odiv)};
  endfunction

endpackage

// File: rtl/pll_mode_sequencer_if.sv
// Control/status bundle between the top level and the mode sequencer.
interface pll_mode_sequencer_if #(
  parameter int MW = 2
);
  logic [MW-1:0] mode_sel;
  logic          mode_req;
  logic [MW-1:0] mode_active;
  logic          ready;
  logic          video_resetn;
  logic          fault;

  modport master (output mode_sel, mode_req,
                  input  mode_active, ready, video_resetn, fault);
  modport slave  (input  mode_sel, mode_req,
                  output mode_active, ready, video_resetn, fault);
endinterface

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the asynchronous rPLL LOCK into clkin.
module pll_lock_sync (
  input  logic clkin,
  input  logic resetn,
  input  logic pll_lock,
  output logic lock_s
);
  logic meta;

  // Plain two-stage capture; cleared so lock is never assumed after reset.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      meta   <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      meta   <= pll_lock;
      lock_s <= meta;
    end
  end
endmodule

// File: rtl/pll_mode_sequencer.sv
// Sequences rPLL divider changes, supervises lock and gates the video reset.
module pll_mode_sequencer
  import pll_mode_pkg::*;
#(
  parameter int NUM_MODES     = 4,
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 4096,
  parameter int MAX_RETRY     = 3
)(
  input  logic                  clkin,
  input  logic                  resetn,
  pll_mode_sequencer_if.slave   ctl,
  input  logic                  pll_lock,
  output logic                  pll_reset,
  output logic [5:0]            idsel,
  output logic [5:0]            fbdsel,
  output logic [5:0]            odsel
);
  localparam int MW    = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
  localparam int CMAX1 = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CMAX  = (CMAX1 > STABLE_CYCLES) ? CMAX1 : STABLE_CYCLES;
  localparam int CW    = $clog2(CMAX) + 1;
  localparam int RW    = $clog2(MAX_RETRY + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT   = '1;
  localparam logic [MW:0]   NM        = (MW + 1)'(NUM_MODES);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [RW-1:0]   retry, retry_nxt;
  logic [MW-1:0]   mode_active, mode_nxt;
  logic [MW-1:0]   pend_mode, pend_mode_nxt, tgt_mode;
  logic            pend_vld, pend_vld_nxt, tgt_vld;
  logic            fault, fault_nxt, ready, req_ok, lock_s;
  logic [17:0]     sel_nxt;

  pll_lock_sync u_sync (.clkin(clkin), .resetn(resetn), .pll_lock(pll_lock), .lock_s(lock_s));

  assign req_ok   = ctl.mode_req && ({1'b0, ctl.mode_sel} < NM);
  // A live request is newer than anything parked in the pending slot.
  assign tgt_vld  = req_ok | pend_vld;
  assign tgt_mode = req_ok ? ctl.mode_sel : pend_mode;
  assign sel_nxt  = mode_sels(3'(mode_nxt));

  // State, counters, mode bookkeeping and registered PLL selects.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state       <= PRST;
      cnt         <= '0;
      retry       <= '0;
      mode_active <= '0;
      pend_vld    <= 1'b0;
      pend_mode   <= '0;
      fault       <= 1'b0;
      ready       <= 1'b0;
      {idsel, fbdsel, odsel} <= mode_sels(3'd0);
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      retry       <= retry_nxt;
      mode_active <= mode_nxt;
      pend_vld    <= pend_vld_nxt;
      pend_mode   <= pend_mode_nxt;
      fault       <= fault_nxt;
      ready       <= (state_nxt == RUN);
      // Dividers only move while the PLL is about to be held in reset.
      if (state_nxt == PRST && state != PRST)
        {idsel, fbdsel, odsel} <= sel_nxt;
    end
  end

  // Next-state: reset hold, lock wait with retry/fallback, stability, run.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);
    retry_nxt     = retry;
    mode_nxt      = mode_active;
    fault_nxt     = fault;
    pend_vld_nxt  = pend_vld;
    pend_mode_nxt = pend_mode;
    case (state)
      PRST: if (cnt == RST_LAST) begin
        state_nxt = WLOCK;
        cnt_nxt   = '0;
      end
      WLOCK: if (lock_s) begin
        state_nxt = STAB;
        cnt_nxt   = '0;
      end else if (cnt == TO_LAST) begin
        state_nxt = PRST;
        cnt_nxt   = '0;
        if (int'(retry) + 1 < MAX_RETRY) begin
          retry_nxt = retry + RW'(1);
        end else begin
          retry_nxt = '0;
          mode_nxt  = '0;
          fault_nxt = 1'b1;
        end
      end
      STAB: if (!lock_s) begin
        state_nxt = WLOCK;
        cnt_nxt   = '0;
      end else if (cnt == STAB_LAST) begin
        state_nxt = RUN;
        cnt_nxt   = '0;
        retry_nxt = '0;
      end
      RUN: begin
        cnt_nxt      = '0;
        pend_vld_nxt = 1'b0;
        // A mode change also covers a simultaneous lock loss.
        if (tgt_vld && tgt_mode != mode_active) begin
          state_nxt = PRST;
          mode_nxt  = tgt_mode;
          fault_nxt = 1'b0;
        end else if (!lock_s) begin
          state_nxt = PRST;
        end
      end
    endcase
    if (state != RUN && req_ok) begin
      pend_vld_nxt  = 1'b1;
      pend_mode_nxt = ctl.mode_sel;
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    pll_reset        = (state == PRST);
    ctl.mode_active  = mode_active;
    ctl.ready        = ready;
    ctl.video_resetn = ready;
    ctl.fault        = fault;
  end

endmodule

// File: tb/tb_pll_mode_sequencer.sv
// Scoreboard bench for pll_mode_sequencer with a behavioural rPLL model.
// With the model locking 10 cycles after pll_reset falls, request-to-ready
// latency is RST(4) + lock(10) + sync(2) + FSM sample(1) + STABLE(16) = 33.
module tb_pll_mode_sequencer;
  localparam int N_LOCK = 10;
  localparam logic [17:0] ENC0 = {6'b111101, 6'b110010, 6'b111110};
  localparam logic [17:0] ENC1 = {6'b111100, 6'b001001, 6'b111111};
  localparam logic [17:0] ENC2 = {6'b111011, 6'b000011, 6'b111111};
  localparam logic [17:0] ENC3 = {6'b111011, 6'b000111, 6'b111111};

  logic clkin = 1'b0, resetn = 1'b0;
  logic pll_lock, pll_reset;
  logic [5:0] idsel, fbdsel, odsel;
  logic [17:0] sels;

  pll_mode_sequencer_if #(.MW(3)) ctl_if();

  pll_mode_sequencer #(
    .NUM_MODES(5), .RST_CYCLES(4), .LOCK_TIMEOUT(64), .STABLE_CYCLES(16), .MAX_RETRY(3)
  ) dut (
    .clkin(clkin), .resetn(resetn), .ctl(ctl_if), .pll_lock(pll_lock),
    .pll_reset(pll_reset), .idsel(idsel), .fbdsel(fbdsel), .odsel(odsel)
  );

  always #5 clkin = ~clkin;

  int cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  // PLL model: locks N_LOCK cycles after reset release on a known divider set
  logic m_lock = 1'b0, drop_lock = 1'b0, block_m2 = 1'b0, sel_ok;
  int   m_cnt = 0;
  assign sels   = {idsel, fbdsel, odsel};
  assign sel_ok = (sels == ENC0 || sels == ENC1 || sels == ENC2 || sels == ENC3)
                  && !(block_m2 && sels == ENC2);
  always @(posedge clkin) begin
    if (pll_reset) begin
      m_cnt  <= 0;
      m_lock <= 1'b0;
    end else begin
      if (m_cnt < N_LOCK) m_cnt <= m_cnt + 1;
      m_lock <= (m_cnt >= N_LOCK - 1) && sel_ok;
    end
  end
  assign pll_lock = m_lock & ~drop_lock;

  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  mode;
    logic [17:0] enc;
    logic        flt;
    int          t_req;
    int          lat;
  } exp_t;
  exp_t sb[$];

  task automatic expect_lock(input logic [2:0] m, input logic [17:0] e, input logic f, input int lat);
    exp_t x;
    x.mode = m; x.enc = e; x.flt = f; x.t_req = cyc; x.lat = lat;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  // Monitor: every rising edge of ready is matched against the scoreboard
  logic rdy_q = 1'b0;
  exp_t mx;
  initial begin
    forever begin
      @(posedge clkin);
      #1;
      if (ctl_if.ready && !rdy_q) begin
        chk("sb_pending", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          mx = sb.pop_front();
          chk("mode_active", 32'(ctl_if.mode_active), 32'(mx.mode));
          chk("selects", 32'(sels), 32'(mx.enc));
          chk("fault", 32'(ctl_if.fault), 32'(mx.flt));
          chk("vrst_eq_ready", 32'(ctl_if.video_resetn), 32'(ctl_if.ready));
          if (mx.lat >= 0) chk("latency", 32'(cyc - mx.t_req), 32'(mx.lat));
        end
      end
      rdy_q = ctl_if.ready;
    end
  end

  task automatic drain(input string nm, input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk({nm, "_drained"}, 32'(sb.size()), 0);
  endtask

  task automatic req(input logic [2:0] m);
    ctl_if.mode_sel = m;
    ctl_if.mode_req = 1'b1;
    tick();
    ctl_if.mode_req = 1'b0;
  endtask

  task automatic lock_glitch(output logic fell);
    fell = 1'b0;
    drop_lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) drop_lock = 1'b0;
      if (!ctl_if.ready) begin
        fell = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int bad;
    logic fell;
    ctl_if.mode_sel = '0;
    ctl_if.mode_req = 1'b0;
    repeat (3) tick();

    // reset values
    chk("rst_pll_reset", 32'(pll_reset), 1);
    chk("rst_ready", 32'(ctl_if.ready), 0);
    chk("rst_vrst", 32'(ctl_if.video_resetn), 0);
    chk("rst_mode", 32'(ctl_if.mode_active), 0);
    chk("rst_fault", 32'(ctl_if.fault), 0);
    chk("rst_sels", 32'(sels), 32'(ENC0));

    // power-up lock in mode 0
    expect_lock(3'd0, ENC0, 1'b0, 33);
    resetn = 1'b1;
    drain("powerup", 100);

    // mode change 0 -> 1
    req(3'd1);
    expect_lock(3'd1, ENC1, 1'b0, 33);
    chk("chg_ready_low", 32'(ctl_if.ready), 0);
    chk("chg_sels", 32'(sels), 32'(ENC1));
    n = 0;
    while (pll_reset && n < 20) begin
      n++;
      tick();
    end
    chk("prst_len", 32'(n), 4);
    drain("mode1", 100);

    // same-mode request in RUN changes nothing
    req(3'd1);
    bad = 0;
    repeat (6) begin
      if (!ctl_if.ready || pll_reset) bad++;
      tick();
    end
    chk("same_mode_glitch", 32'(bad), 0);

    // one-cycle lock loss -> relock in same mode
    lock_glitch(fell);
    chk("lockloss_ready", 32'(fell), 1);
    chk("lockloss_prst", 32'(pll_reset), 1);
    expect_lock(3'd1, ENC1, 1'b0, -1);
    drain("relock", 100);

    // requests during STAB: 1 then 3 then out-of-range 5
    lock_glitch(fell);
    chk("lockloss2_ready", 32'(fell), 1);
    expect_lock(3'd1, ENC1, 1'b0, -1);
    expect_lock(3'd3, ENC3, 1'b0, -1);
    repeat (20) tick();
    req(3'd1);
    req(3'd3);
    req(3'd5);
    n = 0;
    while (!ctl_if.ready && n < 30) begin
      tick();
      n++;
    end
    chk("run_seen", 32'(ctl_if.ready), 1);
    tick();
    chk("run_one_cycle", 32'(ctl_if.ready), 0);
    chk("pend_mode", 32'(ctl_if.mode_active), 3);
    drain("pending", 100);

    // mode 2 never locks -> 3 timeouts -> fallback to mode 0 with fault
    block_m2 = 1'b1;
    req(3'd2);
    expect_lock(3'd0, ENC0, 1'b1, 237);
    chk("m2_sels", 32'(sels), 32'(ENC2));
    drain("fallback", 400);

    // next accepted request clears fault
    req(3'd1);
    chk("fault_clr", 32'(ctl_if.fault), 0);
    expect_lock(3'd1, ENC1, 1'b0, 33);
    drain("after_fault", 100);

    // reset asserted during WLOCK
    req(3'd3);
    repeat (6) tick();
    resetn = 1'b0;
    #1;
    chk("mid_rst_pll_reset", 32'(pll_reset), 1);
    chk("mid_rst_ready", 32'(ctl_if.ready), 0);
    chk("mid_rst_vrst", 32'(ctl_if.video_resetn), 0);
    chk("mid_rst_mode", 32'(ctl_if.mode_active), 0);
    chk("mid_rst_sels", 32'(sels), 32'(ENC0));
    tick();
    expect_lock(3'd0, ENC0, 1'b0, 33);
    resetn = 1'b1;
    drain("restart", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
